// File: rtl/led_pwm_sched.sv
// led_pwm_sched: shares one LED PWM among four prioritized requesters (solid/blink/breathe patterns).
// Optional fade-out on ownership change is built when LED_PWM_SCHED_FADE_EN is defined.
module led_pwm_sched #(
    parameter int STEP_DIV  = 4096,
    parameter int FADE_STEP = 8
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [7:0] mode,
    input  logic [7:0] max_duty,
    output logic [3:0] grant,
    output logic [7:0] duty,
    output logic       led_drive
);
    localparam int             SW        = $clog2(STEP_DIV);
    localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_DIV - 1);

    if (STEP_DIV < 2) begin : g_chk_div
        $error("led_pwm_sched: STEP_DIV must be >= 2");
    end
    if (FADE_STEP < 1 || FADE_STEP > 255) begin : g_chk_fade
        $error("led_pwm_sched: FADE_STEP must be 1..255");
    end

`ifdef LED_PWM_SCHED_FADE_EN
    localparam logic [7:0] FADE_DEC = 8'(FADE_STEP);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FADE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [7:0]    phase_q, phase_d;
    logic [7:0]    level_q, level_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic          led_q, led_d;

    logic          tick;
    logic [3:0]    pick;
    logic [1:0]    own_mode;
    logic          own_req;
    logic          above_req;
    logic          exit_w;
    logic [7:0]    tri_w;
    logic [7:0]    pattern;

    assign tick = (step_cnt_q == STEP_LAST);

    // Fixed priority: bit 3 wins.
    always_comb begin
        pick = 4'b0000;
        if (req[3])      pick = 4'b1000;
        else if (req[2]) pick = 4'b0100;
        else if (req[1]) pick = 4'b0010;
        else if (req[0]) pick = 4'b0001;
    end

    always_comb begin
        own_mode  = 2'b11;
        own_req   = 1'b0;
        above_req = 1'b0;
        case (grant_q)
            4'b1000: begin own_mode = mode[7:6]; own_req = req[3]; above_req = 1'b0;      end
            4'b0100: begin own_mode = mode[5:4]; own_req = req[2]; above_req = req[3];    end
            4'b0010: begin own_mode = mode[3:2]; own_req = req[1]; above_req = |req[3:2]; end
            4'b0001: begin own_mode = mode[1:0]; own_req = req[0]; above_req = |req[3:1]; end
            default: ;
        endcase
    end

    assign exit_w = ~own_req | above_req;

    // Breathe is a triangle over the 256-step phase, peaking at 254 near phase 127/128.
    always_comb begin
        tri_w = phase_q[7] ? {~phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
        case (own_mode)
            2'b00:   pattern = max_duty;
            2'b01:   pattern = phase_q[5] ? 8'd0 : max_duty;
            2'b10:   pattern = (tri_w < max_duty) ? tri_w : max_duty;
            default: pattern = 8'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        phase_d = phase_q;
        level_d = level_q;
        case (state_q)
            IDLE: begin
                level_d = 8'd0;
                if (req != 4'b0000) begin
                    grant_d = pick;
                    phase_d = 8'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (exit_w) begin
`ifdef LED_PWM_SCHED_FADE_EN
                    state_d = FADE;
`else
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    level_d = 8'd0;
`endif
                end else begin
                    level_d = pattern;
                    if (tick) phase_d = phase_q + 8'd1;
                end
            end
`ifdef LED_PWM_SCHED_FADE_EN
            FADE: begin
                if (level_q == 8'd0) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                end else if (tick) begin
                    level_d = (level_q > FADE_DEC) ? level_q - FADE_DEC : 8'd0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                level_d = 8'd0;
            end
        endcase
    end

    // Duty only changes at the period boundary so each PWM period is whole.
    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 8'd1;
        step_cnt_d = tick ? '0 : step_cnt_q + SW'(1);
        duty_d     = (pwm_cnt_q == 8'hFF) ? level_q : duty_q;
        led_d      = (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            phase_q    <= 8'd0;
            level_q    <= 8'd0;
            pwm_cnt_q  <= 8'd0;
            step_cnt_q <= '0;
            duty_q     <= 8'd0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            phase_q    <= phase_d;
            level_q    <= level_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            duty_q     <= duty_d;
            led_q      <= led_d;
        end
    end

    assign grant     = grant_q;
    assign duty      = duty_q;
    assign led_drive = led_q;

endmodule

// File: tb/tb_led_pwm_sched.sv
// Bench for led_pwm_sched: vector table plus hand sequences, checked through an expected-value queue.
module tb_led_pwm_sched;
    localparam int STEP_DIV  = 4;
    localparam int FADE_STEP = 64;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] req      = 4'b0000;
    logic [7:0] mode     = 8'h00;
    logic [7:0] max_duty = 8'd0;
    logic [3:0] grant;
    logic [7:0] duty;
    logic       led_drive;

    int checks = 0;
    int errors = 0;
    int cyc;

    led_pwm_sched #(.STEP_DIV(STEP_DIV), .FADE_STEP(FADE_STEP)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .req      (req),
        .mode     (mode),
        .max_duty (max_duty),
        .grant    (grant),
        .duty     (duty),
        .led_drive(led_drive)
    );

    always #5 sysclk = ~sysclk;

    // Posedges since reset release; equals the DUT's free-running pwm/step counters.
    always @(posedge sysclk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [3:0] req;
        logic [7:0] mode;
        logic [7:0] maxd;
        logic [3:0] gnt;
        logic [7:0] duty;
    } vec_t;
    vec_t vt[7];

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] act);
        sb_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow actual %0d", act);
            return;
        end
        e = sbq.pop_front();
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", e.name, act, e.exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        req   = 4'b0000;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
    endtask

    task automatic wait_to(input int target);
        int g;
        g = 0;
        while (cyc < target && g < 3000) begin
            @(negedge sysclk);
            g++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_to actual %0d expected %0d", cyc, target);
        end
    endtask

    task automatic count_led(output int highs);
        highs = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge sysclk);
            if (led_drive) highs++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int g;

        // Grant one cycle after drive at cyc 10; duty sampled at the cyc-256 boundary where phase=61.
        vt[0] = '{4'b0001, 8'h00, 8'd128, 4'b0001, 8'd128};
        vt[1] = '{4'b0110, 8'h20, 8'd200, 4'b0100, 8'd122};
        vt[2] = '{4'b1111, 8'hC0, 8'd255, 4'b1000, 8'd0};
        vt[3] = '{4'b0011, 8'h03, 8'd90,  4'b0010, 8'd90};
        vt[4] = '{4'b1001, 8'h00, 8'd255, 4'b1000, 8'd255};
        vt[5] = '{4'b0100, 8'h10, 8'd77,  4'b0100, 8'd0};
        vt[6] = '{4'b0010, 8'h08, 8'd50,  4'b0010, 8'd50};

        do_reset();
        #1;
        sb_push("reset_grant", 0); sb_check(grant);
        sb_push("reset_duty", 0);  sb_check(duty);
        sb_push("reset_led", 0);   sb_check(led_drive);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            wait_to(10);
            req      = vt[i].req;
            mode     = vt[i].mode;
            max_duty = vt[i].maxd;
            sb_push($sformatf("v%0d_grant", i), vt[i].gnt);
            sb_push($sformatf("v%0d_duty_pre", i), 0);
            sb_push($sformatf("v%0d_duty", i), vt[i].duty);
            @(negedge sysclk);
            sb_check(grant);
            wait_to(255);
            sb_check(duty);
            wait_to(256);
            sb_check(duty);
            req = 4'b0000;
            sb_push($sformatf("v%0d_release", i), 0);
`ifdef LED_PWM_SCHED_FADE_EN
            g = 0;
            while (grant != 4'b0000 && g < 80) begin
                @(negedge sysclk);
                g++;
            end
`else
            @(negedge sysclk);
`endif
            sb_check(grant);
        end

        // Solid 128: half-on PWM, then asynchronous reset while the LED is lit.
        do_reset();
        wait_to(10);
        req = 4'b0001; mode = 8'h00; max_duty = 8'd128;
        wait_to(256);
        sb_push("solid_duty", 128); sb_check(duty);
        count_led(n);
        sb_push("solid_highs", 128); sb_check(n);
        wait_to(513);
        sb_push("run_led_high", 1); sb_check(led_drive);
        reset = 1'b1;
        #1;
        sb_push("arst_grant", 0); sb_check(grant);
        sb_push("arst_duty", 0);  sb_check(duty);
        sb_push("arst_led", 0);   sb_check(led_drive);
        repeat (3) @(negedge sysclk);
        sb_push("arst_hold_grant", 0); sb_check(grant);
        sb_push("arst_hold_led", 0);   sb_check(led_drive);
        req   = 4'b0000;
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        sb_push("post_rst_idle", 0); sb_check(grant);
        req = 4'b0001;
        @(negedge sysclk);
        sb_push("post_rst_grant", 1); sb_check(grant);

        // Preemption by a higher requester.
        do_reset();
        wait_to(10);
        req = 4'b0001; mode = 8'h00; max_duty = 8'd200;
        @(negedge sysclk);
        sb_push("pre_owner", 4'b0001); sb_check(grant);
`ifdef LED_PWM_SCHED_FADE_EN
        // Exit at posedge 21; ticks at 24,28,32,36 give 136,72,8,0; IDLE at 37; req[3] wins at 38.
        wait_to(20);
        req = 4'b0000;
        wait_to(25);
        req = 4'b1000;
        wait_to(36);
        sb_push("fade_held", 4'b0001); sb_check(grant);
        @(negedge sysclk);
        sb_push("fade_idle", 4'b0000); sb_check(grant);
        @(negedge sysclk);
        sb_push("fade_regrant", 4'b1000); sb_check(grant);
`else
        req = 4'b0101;
        @(negedge sysclk);
        sb_push("pre_gap", 4'b0000); sb_check(grant);
        @(negedge sysclk);
        sb_push("pre_new", 4'b0100); sb_check(grant);
`endif

        // Breathe, grant at 192: boundary phases 15,79,143,207,15 -> 30,100(clip),100(clip),96,30.
        do_reset();
        wait_to(191);
        req = 4'b0001; mode = 8'h02; max_duty = 8'd100;
        sb_push("breathe_b1", 30);
        sb_push("breathe_b2", 100);
        sb_push("breathe_b3", 100);
        sb_push("breathe_b4", 96);
        sb_push("breathe_b5", 30);
        for (int m = 1; m <= 5; m++) begin
            wait_to(256 * m);
            sb_check(duty);
        end

        // Blink sampled in its on half: duty 255 leaves exactly one low cycle per period.
        do_reset();
        wait_to(191);
        req = 4'b0001; mode = 8'h01; max_duty = 8'd255;
        wait_to(256);
        sb_push("blink_on_duty", 255); sb_check(duty);
        count_led(n);
        sb_push("blink_on_lows", 1); sb_check(256 - n);

        // Blink sampled in its off half (phase 47, 111).
        do_reset();
        wait_to(63);
        req = 4'b0001; mode = 8'h01; max_duty = 8'd255;
        wait_to(256);
        sb_push("blink_off_duty1", 0); sb_check(duty);
        wait_to(512);
        sb_push("blink_off_duty2", 0); sb_check(duty);

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual %0d expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pwm_sched.md
# led_pwm_sched

Scheduler that shares one LED PWM output among four prioritized status requesters (e.g. fault, watchdog, host command, heartbeat). It grants the LED to the highest-priority active requester, generates that requester's brightness pattern (solid, blink or breathe), and drives a glitch-free 256-step PWM. On the FPGA1394-QLA board it sits between the status logic and the LED pin, in place of a fixed per-LED PWM.

## Interface
- STEP_DIV, 4096: sysclk cycles per pattern step tick (≥2).
- FADE_STEP, 8: duty decrement per step tick during fade-out (1–255).
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  request lines; bit 3 highest priority, bit 0 lowest.
- mode  in  8  pattern per requester; bits [2i+1:2i] for req[i]: 00 solid, 01 blink, 10 breathe, 11 off.
- max_duty  in  8  brightness ceiling applied to all patterns.
- grant  out  4  one-hot current owner; 0 when idle.
- duty  out  8  duty currently applied to the PWM.
- led_drive  out  1  PWM output to the LED.

## Operation
- Reset values: grant=0, duty=0, led_drive=0, state=IDLE; pwm_cnt, step_cnt, phase and level all 0.
- pwm_cnt: 8-bit free-running, +1 every sysclk, wraps 255→0.
- step_cnt: counts 0..STEP_DIV-1; tick=1 for one cycle when step_cnt==STEP_DIV-1, then step_cnt returns to 0.
- level: 8-bit target duty. duty loads level only when pwm_cnt==255, so a new duty takes effect at the start of a PWM period.
- led_drive <= (pwm_cnt < duty). duty=0 gives constantly low; duty=255 gives 255/256 high.
- FSM states: IDLE, RUN, FADE (FADE exists only with the macro).
- IDLE: level=0. If req≠0, then next cycle grant=onehot(highest set bit), phase=0, state=RUN. Otherwise grant stays 0.
- RUN, pattern computed each cycle from mode of owner o:
  - solid: level=max_duty.
  - blink: level = phase[5] ? 0 : max_duty.
  - breathe: t = phase[7] ? {~phase[6:0],1'b0} : {phase[6:0],1'b0}; level=min(t,max_duty).
  - off: level=0.
- RUN: phase increments on tick and wraps at 255. mode and max_duty changes apply on the next cycle.
- RUN exit condition: req[o]==0, or any req bit above o is set. The exit path depends on the macro (see Configuration).
- FADE: grant is held and phase is frozen. On each tick, level = (level>FADE_STEP) ? level-FADE_STEP : 0. When level==0, state=IDLE and grant=0, and re-arbitration follows on the next cycle. Requests that change during FADE do not abort the fade.
- Simultaneous exit condition and tick: the exit takes priority and phase does not advance.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and led_drive drops low without waiting for a PWM boundary.

## Timing
- req rising in IDLE leads to grant valid 1 cycle later.
- New level reaches duty at the next cycle where pwm_cnt==255. duty reaches led_drive 1 cycle later (registered). Worst-case latency from level to pin is 257 cycles.
- Blink period = 64 ticks. Breathe period = 256 ticks.
- Fade worst case = ceil(255/FADE_STEP) ticks + 1 cycle.
- Handover time from owner drop to the new grant without the macro is 2 cycles (RUN→IDLE, IDLE→RUN).

## Configuration
- LED_PWM_SCHED_FADE_EN defined: RUN exit goes to FADE, giving a ramp-down before the LED is re-granted.
- LED_PWM_SCHED_FADE_EN undefined: RUN exit goes directly to IDLE with grant=0 and level=0 in the same cycle. No FADE state or FADE_STEP logic is synthesized, and FADE_STEP is ignored.

## Test plan
- Reset with STEP_DIV=4: drive req=4'b0001, mode=00, max_duty=128 → grant=0001 after 1 cycle; duty=128 at the next pwm_cnt==255; led_drive high for exactly 128 of every 256 cycles.
- Preemption without the macro: owner req[0] active, then raise req[2] → grant 0001→0000→0100 over consecutive cycles; level 0 for one cycle.
- Preemption with the macro, FADE_STEP=64, level=200: drop req[0] → level goes 136, 72, 8, 0 on successive ticks, grant held at 0001, then grant=0 and IDLE.
- Breathe with max_duty=100 → level follows the triangle, clips at 100, reaches its minimum at phase 255/0, and repeats every 256 ticks.
- Blink with max_duty=255 → level 255 for 32 ticks, then 0 for 32 ticks; duty=255 gives led_drive low for exactly 1 cycle per period.
- Assert reset mid-RUN with led_drive high → grant, duty and led_drive are 0 the same cycle, and stay 0 until reset is released and a req is seen.
